// File: rtl/midi_pkg.sv
// Shared MIDI definitions: voice types, byte-FSM states and per-type helpers
// used by both the transmit encoder and the receive parser.
package midi_pkg;

  localparam int unsigned DATA_W = 7;
  localparam int unsigned CHAN_W = 4;
  localparam logic [7:0]  MIDI_STATUS_BIT = 8'h80;

  typedef enum logic [2:0] {
    VOICE_NOTE_OFF = 3'd0,
    VOICE_NOTE_ON  = 3'd1,
    VOICE_POLY_AT  = 3'd2,
    VOICE_CTRL     = 3'd3,
    VOICE_PROGRAM  = 3'd4,
    VOICE_CHAN_AT  = 3'd5,
    VOICE_PITCH    = 3'd6,
    VOICE_INVALID  = 3'd7
  } t_voice;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STATUS = 2'd1,
    S_DATA1  = 2'd2,
    S_DATA2  = 2'd3
  } t_enc_state;

  // Number of data bytes following the status byte; 0 for an invalid type.
  function automatic logic [1:0] data_len(input t_voice voice);
    case (voice)
      VOICE_PROGRAM, VOICE_CHAN_AT: data_len = 2'd1;
      VOICE_INVALID:                data_len = 2'd0;
      default:                      data_len = 2'd2;
    endcase
  endfunction

  function automatic logic [7:0] status_byte(input t_voice voice,
                                             input logic [CHAN_W-1:0] channel);
    status_byte = MIDI_STATUS_BIT | {1'b0, voice, channel};
  endfunction

endpackage

// File: rtl/midi_running_status.sv
// Running-status tracker: remembers the last status sent and decides whether
// the next accepted message must carry an explicit status byte.
module midi_running_status
  import midi_pkg::*;
#(
  parameter int unsigned RUNNING_STATUS = 1,
  parameter int unsigned REFRESH_MSGS   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       accept,
  input  logic       rs_clear,
  input  logic [7:0] status,
  output logic       need_status_c
);

  localparam int unsigned SKIP_W = (REFRESH_MSGS > 0) ? $clog2(REFRESH_MSGS + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(REFRESH_MSGS);

  logic [7:0]        last_status;
  logic              last_valid;
  logic [SKIP_W-1:0] skip_cnt;
  logic              refresh_due;

  assign refresh_due = (REFRESH_MSGS != 0) && (skip_cnt == SKIP_MAX);

  // A coincident rs_clear forces the status byte for the message being accepted.
  assign need_status_c = (RUNNING_STATUS == 0) || rs_clear || !last_valid ||
                         (last_status != status) || refresh_due;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_status <= 8'h00;
      last_valid  <= 1'b0;
      skip_cnt    <= '0;
    end else if (accept) begin
      if (need_status_c) begin
        last_status <= status;
        last_valid  <= 1'b1;
        skip_cnt    <= '0;
      end else if (skip_cnt != SKIP_MAX) begin
        skip_cnt <= skip_cnt + SKIP_W'(1);
      end
    end else if (rs_clear) begin
      last_valid <= 1'b0;
      skip_cnt   <= '0;
    end
  end

endmodule

// File: rtl/midi_encoder.sv
// MIDI voice-message encoder: serializes one channel-voice event per handshake
// into status/data bytes for the UART transmitter, with running status.
module midi_encoder
  import midi_pkg::*;
#(
  parameter int unsigned RUNNING_STATUS = 1,
  parameter int unsigned REFRESH_MSGS   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       v_valid,
  output logic       v_ready,
  input  logic [2:0] v_type,
  input  logic [3:0] v_channel,
  input  logic [6:0] v_data1,
  input  logic [6:0] v_data2,
  input  logic       rs_clear,
  output logic [7:0] d_out,
  output logic       d_valid,
  input  logic       d_ready
);

  t_enc_state        state;
  t_voice            voice;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              two_bytes;
  logic [7:0]        status;
  logic              accept;
  logic              msg_accept;
  logic              xfer;
  logic              need_status_c;

  assign v_ready    = (state == S_IDLE) && !reset;
  assign accept     = v_valid && v_ready;
  assign voice      = t_voice'(v_type);
  assign status     = status_byte(voice, v_channel);
  assign msg_accept = accept && (voice != VOICE_INVALID);
  assign xfer       = d_valid && d_ready;

  midi_running_status #(
    .RUNNING_STATUS (RUNNING_STATUS),
    .REFRESH_MSGS   (REFRESH_MSGS)
  ) u_running_status (
    .clk           (clk),
    .reset         (reset),
    .accept        (msg_accept),
    .rs_clear      (rs_clear),
    .status        (status),
    .need_status_c (need_status_c)
  );

  // Byte FSM; invalid-type events are accepted in IDLE and simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      d_out     <= 8'h00;
      d_valid   <= 1'b0;
      data1     <= '0;
      data2     <= '0;
      two_bytes <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (msg_accept) begin
            data1     <= v_data1;
            data2     <= v_data2;
            two_bytes <= (data_len(voice) == 2'd2);
            d_valid   <= 1'b1;
            if (need_status_c) begin
              state <= S_STATUS;
              d_out <= status;
            end else begin
              state <= S_DATA1;
              d_out <= {1'b0, v_data1};
            end
          end
        end
        S_STATUS: begin
          if (xfer) begin
            state <= S_DATA1;
            d_out <= {1'b0, data1};
          end
        end
        S_DATA1: begin
          if (xfer) begin
            if (two_bytes) begin
              state <= S_DATA2;
              d_out <= {1'b0, data2};
            end else begin
              state   <= S_IDLE;
              d_valid <= 1'b0;
            end
          end
        end
        S_DATA2: begin
          if (xfer) begin
            state   <= S_IDLE;
            d_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_encoder.sv
// Self-checking bench for midi_encoder: byte-queue reference model checked on
// every transfer, plus literal byte sequences for the directed scenarios.
module tb_midi_encoder;

  localparam int REFRESH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       v_valid = 1'b0;
  logic       v_ready;
  logic [2:0] v_type = 3'd0;
  logic [3:0] v_channel = 4'd0;
  logic [6:0] v_data1 = 7'd0;
  logic [6:0] v_data2 = 7'd0;
  logic       rs_clear = 1'b0;
  logic [7:0] d_out;
  logic       d_valid;
  logic       d_ready = 1'b1;

  midi_encoder #(
    .RUNNING_STATUS (1),
    .REFRESH_MSGS   (REFRESH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .v_valid   (v_valid),
    .v_ready   (v_ready),
    .v_type    (v_type),
    .v_channel (v_channel),
    .v_data1   (v_data1),
    .v_data2   (v_data2),
    .rs_clear  (rs_clear),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .d_ready   (d_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state: expected byte stream and running-status memory.
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       m_valid = 1'b0;
  logic [7:0] m_last = 8'h00;
  int         m_skip = 0;
  logic       hold_chk = 1'b0;
  logic [7:0] hold_byte = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model reaction to the inputs that the coming clock edge will sample.
  task automatic model_edge();
    logic [7:0] st;
    logic       need;
    if (reset) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_skip  = 0;
    end else begin
      if (rs_clear) begin
        m_valid = 1'b0;
        m_skip  = 0;
      end
      if (v_valid && v_ready && v_type != 3'd7) begin
        st   = {1'b1, v_type, v_channel};
        need = !m_valid || (m_last != st) || (m_skip == REFRESH);
        if (need) begin
          exp_q.push_back(st);
          m_last  = st;
          m_valid = 1'b1;
          m_skip  = 0;
        end else if (m_skip < REFRESH) begin
          m_skip++;
        end
        exp_q.push_back({1'b0, v_data1});
        if (v_type != 3'd4 && v_type != 3'd5) exp_q.push_back({1'b0, v_data2});
      end
    end
  endtask

  // Called at a negedge once this cycle's inputs are final; then advances.
  task automatic step();
    logic [7:0] e;
    if (hold_chk) chk("backpressure hold", int'({d_valid, d_out}), int'({1'b1, hold_byte}));
    if (!reset && d_valid === 1'b1 && d_ready) begin
      got_q.push_back(d_out);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected byte: got 0x%0h expected none", d_out);
      end else begin
        e = exp_q.pop_front();
        chk("stream byte", int'(d_out), int'(e));
      end
    end
    hold_chk  = !reset && (d_valid === 1'b1) && !d_ready;
    hold_byte = d_out;
    model_edge();
    @(negedge clk);
  endtask

  task automatic send(input int t, input int ch, input int a, input int b, input bit clr);
    bit acc = 1'b0;
    v_type    = 3'(t);
    v_channel = 4'(ch);
    v_data1   = 7'(a);
    v_data2   = 7'(b);
    v_valid   = 1'b1;
    rs_clear  = clr;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = v_ready;
      step();
    end
    v_valid  = 1'b0;
    rs_clear = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept timeout: got v_ready=0 expected 1");
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (exp_q.size() == 0 && d_valid === 1'b0) done = 1'b1;
      else step();
    end
    chk("drain", int'(done), 1);
  endtask

  task automatic check_log(input string name, input int n, input int b0, input int b1, input int b2);
    int exp_b[3];
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
    chk({name, " length"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk({name, " byte"}, int'(got_q[i]), exp_b[i]);
    got_q.delete();
  endtask

  task automatic pulse_clear();
    rs_clear = 1'b1;
    step();
    rs_clear = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) step();
    chk("reset v_ready", int'(v_ready), 0);
    chk("reset d_valid", int'(d_valid), 0);
    chk("reset d_out", int'(d_out), 'h00);
    reset = 1'b0;
    step();
    chk("post-reset v_ready", int'(v_ready), 1);

    // Note on ch0 60/100, cycle by cycle.
    send(1, 0, 60, 100, 1'b0);
    chk("note on cyc1", int'({d_valid, d_out}), 'h190);
    step();
    chk("note on cyc2", int'({d_valid, d_out}), 'h13C);
    step();
    chk("note on cyc3", int'({d_valid, d_out}), 'h164);
    step();
    chk("note on ready back", int'({v_ready, d_valid}), 'b10);
    drain();
    check_log("note on", 3, 'h90, 'h3C, 'h64);

    send(1, 0, 62, 100, 1'b0);
    drain();
    check_log("running status", 2, 'h3E, 'h64, 0);
    send(0, 1, 60, 0, 1'b0);
    drain();
    check_log("note off ch1", 3, 'h81, 'h3C, 'h00);
    send(4, 2, 5, 77, 1'b0);
    drain();
    check_log("program change", 2, 'hC2, 'h05, 0);

    send(7, 3, 1, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("invalid type idle", int'({v_ready, d_valid}), 'b10);
      step();
    end
    check_log("invalid type", 0, 0, 0, 0);

    // Backpressure while DATA1 is pending.
    send(1, 0, 60, 100, 1'b0);
    step();
    d_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall data1", int'({d_valid, d_out}), 'h13C);
      step();
    end
    d_ready = 1'b1;
    drain();
    check_log("backpressure", 3, 'h90, 'h3C, 'h64);

    // Reset while DATA1 is pending (status omitted by running status).
    d_ready = 1'b0;
    send(1, 0, 60, 100, 1'b0);
    step();
    chk("pre-reset data1", int'({d_valid, d_out}), 'h13C);
    reset = 1'b1;
    step();
    chk("abort d_valid", int'(d_valid), 0);
    chk("abort v_ready", int'(v_ready), 0);
    step();
    reset = 1'b0;
    d_ready = 1'b1;
    step();
    chk("abort ready back", int'(v_ready), 1);
    check_log("aborted", 0, 0, 0, 0);
    send(1, 0, 60, 100, 1'b0);
    drain();
    check_log("after reset", 3, 'h90, 'h3C, 'h64);

    // Forced refresh every third status-less message.
    pulse_clear();
    for (int m = 0; m < 4; m++) begin
      send(1, 0, 60, 100, 1'b0);
      drain();
      if (m == 0 || m == 3) check_log("refresh status", 3, 'h90, 'h3C, 'h64);
      else check_log("refresh skip", 2, 'h3C, 'h64, 0);
    end

    // rs_clear as a separate pulse and coincident with an accept.
    pulse_clear();
    send(1, 0, 60, 100, 1'b0);
    drain();
    check_log("clear msg1", 3, 'h90, 'h3C, 'h64);
    pulse_clear();
    send(1, 0, 60, 100, 1'b0);
    drain();
    check_log("clear msg2", 3, 'h90, 'h3C, 'h64);
    send(1, 0, 60, 100, 1'b1);
    drain();
    check_log("clear coincident", 3, 'h90, 'h3C, 'h64);
    send(1, 0, 60, 100, 1'b0);
    drain();
    check_log("after clear skip", 2, 'h3C, 'h64, 0);

    chk("queue empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
